// File: rtl/mul_iter_pkg.sv
// Shared types and parameter helpers for the mul_iter iterative multiply/MAC core.
package mul_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int steps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  // Legal: WIDTH>=2, digit of 1/2/4 bits dividing WIDTH, accumulator holds a full product.
  function automatic bit params_ok(input int width, input int bits_per_cycle, input int acc_bits);
    return (width >= 2) &&
           (bits_per_cycle == 1 || bits_per_cycle == 2 || bits_per_cycle == 4) &&
           (width % bits_per_cycle == 0) &&
           (acc_bits >= 2 * width);
  endfunction

endpackage

// File: rtl/mul_iter_step.sv
// One radix-2^BITS_PER_CYCLE shift-add step: adds digit * (pre-shifted multiplicand).
module mul_iter_step #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [2*WIDTH-1:0]        psum,
  input  logic [2*WIDTH-1:0]        mcand,
  input  logic [BITS_PER_CYCLE-1:0] digit,
  output logic [2*WIDTH-1:0]        psum_next
);

  always_comb begin
    psum_next = psum;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (digit[i]) psum_next = psum_next + (mcand << i);
    end
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative multiply / multiply-accumulate core with valid/ready on both sides.
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 2,
  parameter int ACC_BITS       = 2*WIDTH+4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                signed_mode,
  input  logic                acc_en,
  input  logic                acc_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*WIDTH-1:0]  result,
  output logic [ACC_BITS-1:0] acc
);

  localparam int N  = steps(WIDTH, BITS_PER_CYCLE);
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;

  if (!params_ok(WIDTH, BITS_PER_CYCLE, ACC_BITS)) begin : g_bad_params
    $error("mul_iter: illegal WIDTH/BITS_PER_CYCLE/ACC_BITS combination");
  end

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [PW-1:0]       psum, mcand, psum_nx, prod;
  logic [WIDTH-1:0]    mplr, a_mag, b_mag;
  logic                neg, sgn, acc_en_q, acc_clr_q;
  logic                accept, handshake, last;
  logic [ACC_BITS-1:0] prod_ext;

  assign in_ready  = (state == IDLE) && ena;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready && ena;
  assign last      = (state == BUSY) && (cnt == CW'(1));

  // Magnitude of -2^(W-1) is 2^(W-1), which still fits unsigned in W bits.
  assign a_mag = (signed_mode && a[WIDTH-1]) ? WIDTH'(-a) : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? WIDTH'(-b) : b;

  mul_iter_step #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .psum      (psum),
    .mcand     (mcand),
    .digit     (mplr[BITS_PER_CYCLE-1:0]),
    .psum_next (psum_nx)
  );

  assign prod     = neg ? PW'(-psum_nx) : psum_nx;
  assign prod_ext = sgn ? ACC_BITS'($signed(prod)) : ACC_BITS'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)       state_nx = BUSY;
      BUSY:    if (ena && last)  state_nx = DONE;
      DONE:    if (handshake)    state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      psum      <= '0;
      mcand     <= '0;
      mplr      <= '0;
      neg       <= 1'b0;
      sgn       <= 1'b0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      result    <= '0;
      acc       <= '0;
    end else if (ena) begin
      if (accept) begin
        cnt       <= CW'(N);
        psum      <= '0;
        mcand     <= PW'(a_mag);
        mplr      <= b_mag;
        neg       <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
        sgn       <= signed_mode;
        acc_en_q  <= acc_en;
        acc_clr_q <= acc_clr;
      end else if (state == BUSY) begin
        cnt   <= cnt - CW'(1);
        psum  <= psum_nx;
        mcand <= mcand << BITS_PER_CYCLE;
        mplr  <= mplr >> BITS_PER_CYCLE;
        if (last) begin
          result <= prod;
          if (acc_clr_q)     acc <= prod_ext;
          else if (acc_en_q) acc <= acc + prod_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Directed scoreboard bench for mul_iter: three instances cover digit widths 2, 1 and 4.
module tb_mul_iter;

  logic        clk = 1'b0;
  logic        rst_n, ena, sm, ae, ac, ordy;
  logic [7:0]  a, b;
  logic [2:0]  iv, ir, ov;
  logic [15:0] res [3];
  logic [19:0] acc0, acc1;
  logic [15:0] acc4;

  typedef struct {
    int          d;
    logic [15:0] res;
    logic [19:0] acc;
  } exp_t;

  exp_t        sbq[$];
  logic [19:0] mdl_acc [3];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  mul_iter #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a), .b(b), .signed_mode(sm), .acc_en(ae), .acc_clr(ac),
    .out_valid(ov[0]), .out_ready(ordy), .result(res[0]), .acc(acc0));

  mul_iter #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a), .b(b), .signed_mode(sm), .acc_en(ae), .acc_clr(ac),
    .out_valid(ov[1]), .out_ready(ordy), .result(res[1]), .acc(acc1));

  mul_iter #(.WIDTH(8), .BITS_PER_CYCLE(4), .ACC_BITS(16)) u_d4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a), .b(b), .signed_mode(sm), .acc_en(ae), .acc_clr(ac),
    .out_valid(ov[2]), .out_ready(ordy), .result(res[2]), .acc(acc4));

  function automatic logic [19:0] get_acc(input int d);
    case (d)
      0:       return acc0;
      1:       return acc1;
      default: return {4'h0, acc4};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one operation on instance d, check latency and the scoreboard entry,
  // optionally stall DONE for `hold` cycles and freeze ena for `stall` cycles mid-BUSY.
  task automatic do_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                       input logic s, input logic e, input logic c,
                       input int exp_lat, input int hold, input int stall);
    logic [15:0] ax, bx, p, r_hold;
    logic [19:0] ext, a_hold;
    exp_t        y;
    int          cnt;
    bit          seen;
    @(negedge clk);
    a = av; b = bv; sm = s; ae = e; ac = c; iv[d] = 1'b1;
    chk("in_ready_idle", 20'(ir[d]), 20'd1);
    ax  = s ? {{8{av[7]}}, av} : {8'h00, av};
    bx  = s ? {{8{bv[7]}}, bv} : {8'h00, bv};
    p   = ax * bx;
    ext = s ? {{4{p[15]}}, p} : {4'h0, p};
    if (c)      mdl_acc[d] = ext;
    else if (e) mdl_acc[d] = mdl_acc[d] + ext;
    if (d == 2) mdl_acc[d] = {4'h0, mdl_acc[d][15:0]};
    sbq.push_back('{d, p, mdl_acc[d]});
    @(posedge clk); #1;
    iv[d] = 1'b0;
    // Inputs change after accept; they must not affect the result.
    a = ~av; b = ~bv; sm = ~s;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
      if (stall > 0 && cnt == 2)         ena = 1'b0;
      if (stall > 0 && cnt == 2 + stall) ena = 1'b1;
      seen = ov[d];
    end
    chk("latency", 20'(cnt), 20'(exp_lat));
    y = sbq.pop_front();
    chk("result", {4'h0, res[y.d]}, {4'h0, y.res});
    chk("acc", get_acc(y.d), y.acc);
    r_hold = res[d];
    a_hold = get_acc(d);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      iv[d] = (i % 2 == 0);
      a = 8'(i * 37);
      @(posedge clk); #1;
      chk("bp_ready", 20'(ir[d]), 20'd0);
      chk("bp_valid", 20'(ov[d]), 20'd1);
      chk("bp_result", {4'h0, res[d]}, {4'h0, r_hold});
      chk("bp_acc", get_acc(d), a_hold);
    end
    iv[d] = 1'b0;
    @(negedge clk);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("hs_valid_low", 20'(ov[d]), 20'd0);
    chk("hs_ready_high", 20'(ir[d]), 20'd1);
  endtask

  initial begin
    iv = '0; a = '0; b = '0; sm = 1'b0; ae = 1'b0; ac = 1'b0; ordy = 1'b0;
    for (int i = 0; i < 3; i++) mdl_acc[i] = '0;
    rst_n = 1'b0; ena = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", {4'h0, res[0]}, 20'd0);
    chk("rst_acc", acc0, 20'd0);
    chk("rst_valid", 20'(ov), 20'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 20'(ir[0]), 20'd1);

    // Unsigned 200*100 across the three digit widths
    do_op(0, 8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 4, 0, 0);
    chk("u_4e20", {4'h0, res[0]}, 20'h04E20);
    do_op(1, 8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 8, 0, 0);
    chk("u_4e20_bpc1", {4'h0, res[1]}, 20'h04E20);
    do_op(2, 8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 2, 0, 0);
    chk("u_4e20_bpc4", {4'h0, res[2]}, 20'h04E20);

    // Signed corners
    do_op(0, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 4, 0, 0);
    chk("s_80x80", {4'h0, res[0]}, 20'h04000);
    do_op(0, 8'hFF, 8'h02, 1'b1, 1'b0, 1'b0, 4, 0, 0);
    chk("s_ffx02", {4'h0, res[0]}, 20'h0FFFE);
    do_op(0, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 4, 0, 0);
    chk("s_7fx80", {4'h0, res[0]}, 20'h0C080);
    do_op(0, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 4, 0, 0);
    chk("s_00x80", {4'h0, res[0]}, 20'h00000);

    // MAC sequence
    do_op(0, 8'd3, 8'd4, 1'b0, 1'b0, 1'b1, 4, 0, 0);
    chk("mac_clr", acc0, 20'd12);
    do_op(0, 8'd5, 8'd6, 1'b0, 1'b1, 1'b0, 4, 0, 0);
    chk("mac_add", acc0, 20'd42);
    do_op(0, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 4, 0, 0);
    chk("mac_neg", acc0, 20'd41);
    do_op(0, 8'd7, 8'd9, 1'b0, 1'b0, 1'b0, 4, 0, 0);
    chk("mac_hold", acc0, 20'd41);

    // 16-bit accumulator wrap: 0xFF*0xFF = 0xFE01, doubled wraps to 0xFC02
    do_op(2, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 2, 0, 0);
    chk("wrap_load", {4'h0, acc4}, 20'h0FE01);
    do_op(2, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 2, 0, 0);
    chk("wrap_add", {4'h0, acc4}, 20'h0FC02);

    // Back-pressure, then ena freeze mid-BUSY
    do_op(0, 8'd9, 8'd11, 1'b0, 1'b1, 1'b0, 4, 10, 0);
    do_op(0, 8'd13, 8'd17, 1'b1, 1'b1, 1'b0, 9, 0, 5);

    // Reset mid-BUSY discards the operation
    @(negedge clk);
    a = 8'd50; b = 8'd60; sm = 1'b0; ae = 1'b1; ac = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_result", {4'h0, res[0]}, 20'd0);
    chk("mid_rst_acc", acc0, 20'd0);
    chk("mid_rst_acc4", {4'h0, acc4}, 20'd0);
    chk("mid_rst_valid", 20'(ov), 20'd0);
    for (int i = 0; i < 3; i++) mdl_acc[i] = '0;
    @(negedge clk) rst_n = 1'b1;
    do_op(0, 8'hF6, 8'h07, 1'b1, 1'b1, 1'b0, 4, 0, 0);
    chk("post_rst_result", {4'h0, res[0]}, 20'h0FFBA);
    chk("post_rst_acc", acc0, 20'hFFFBA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
